// File: rtl/cnn_maxpool_flatten.sv
// 2x2 stride-2 max-pool of both layer-0 kernels into L1 plus interleaved flatten into L2.
// Define MAXPOOL_CEIL_EN to round each pooled value up to an integer.
module cnn_maxpool_flatten #(
   parameter int DW     = 20,
   parameter int FRAC   = 4,
   parameter int LOG2_W = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  crd,
   output logic [2*LOG2_W-1:0]   caddr_rd,
   input  logic [DW-1:0]         cdata_rd,
   output logic                  cwr,
   output logic [2*LOG2_W-1:0]   caddr_wr,
   output logic [DW-1:0]         cdata_wr,
   output logic [2:0]            csel
);

   localparam int AW = 2*LOG2_W;
   localparam int PW = LOG2_W-1;
   localparam int IW = DW-FRAC;
   localparam logic [PW-1:0] P_LAST = '1;
   localparam logic [PW-1:0] P_ONE  = PW'(1);
   localparam logic [IW-1:0] I_ONE  = IW'(1);
   localparam logic [IW-1:0] I_MAX  = {1'b0, {(IW-1){1'b1}}};

`ifdef MAXPOOL_CEIL_EN
   localparam bit CEIL_EN = 1'b1;
`else
   localparam bit CEIL_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      IDLE, RD0, RD1, RD2, RD3, CMP, WR1, WR2, FIN
   } state_t;

   state_t          state, state_n;
   logic            k, k_n;
   logic [PW-1:0]   r, r_n, c, c_n;
   logic [DW-1:0]   mx, mx_n;
   logic [DW-1:0]   pick, pooled;
   logic [IW-1:0]   ipart;
   logic [FRAC-1:0] fpart;
   logic            last;

   logic            busy_n, done_n, crd_n, cwr_n;
   logic [2:0]      csel_n;
   logic [AW-1:0]   caddr_rd_n, caddr_wr_n;
   logic [DW-1:0]   cdata_wr_n;

   // Strict greater-than: a tie keeps the held value.
   assign pick  = ($signed(cdata_rd) > $signed(mx)) ? cdata_rd : mx;
   assign ipart = pick[DW-1:FRAC];
   assign fpart = pick[FRAC-1:0];
   assign last  = k && (r == P_LAST) && (c == P_LAST);

   always_comb begin
      pooled = pick;
      if (CEIL_EN && (fpart != '0)) begin
         if (ipart == I_MAX)
            pooled = {I_MAX, {FRAC{1'b0}}};
         else
            pooled = {ipart + I_ONE, {FRAC{1'b0}}};
      end
   end

   always_comb begin
      state_n = state;
      k_n     = k;
      r_n     = r;
      c_n     = c;
      mx_n    = mx;
      unique case (state)
         IDLE: if (start) state_n = RD0;
         RD0:  state_n = RD1;
         RD1: begin
            state_n = RD2;
            mx_n    = cdata_rd;
         end
         RD2: begin
            state_n = RD3;
            mx_n    = pick;
         end
         RD3: begin
            state_n = CMP;
            mx_n    = pick;
         end
         CMP:  state_n = WR1;
         WR1:  state_n = WR2;
         WR2: begin
            // Wrap of all three counters on the last pixel leaves them at 0.
            c_n = c + P_ONE;
            if (c == P_LAST) begin
               r_n = r + P_ONE;
               if (r == P_LAST) k_n = ~k;
            end
            state_n = last ? FIN : RD0;
         end
         FIN:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port is a flop.
   always_comb begin
      busy_n     = (state_n != IDLE) && (state_n != FIN);
      done_n     = (state_n == FIN);
      crd_n      = 1'b0;
      cwr_n      = 1'b0;
      csel_n     = 3'b000;
      caddr_rd_n = caddr_rd;
      caddr_wr_n = caddr_wr;
      cdata_wr_n = cdata_wr;
      unique case (1'b1)
         (state_n == RD0): caddr_rd_n = {r_n, 1'b0, c_n, 1'b0};
         (state_n == RD1): caddr_rd_n = {r_n, 1'b0, c_n, 1'b1};
         (state_n == RD2): caddr_rd_n = {r_n, 1'b1, c_n, 1'b0};
         (state_n == RD3): caddr_rd_n = {r_n, 1'b1, c_n, 1'b1};
         (state_n == WR1): begin
            cwr_n      = 1'b1;
            csel_n     = k_n ? 3'b100 : 3'b011;
            caddr_wr_n = {2'b00, r_n, c_n};
            cdata_wr_n = pooled;
         end
         (state_n == WR2): begin
            cwr_n      = 1'b1;
            csel_n     = 3'b101;
            caddr_wr_n = {1'b0, r_n, c_n, k_n};
         end
         default: ;
      endcase
      if ((state_n == RD0) || (state_n == RD1) ||
          (state_n == RD2) || (state_n == RD3)) begin
         crd_n  = 1'b1;
         csel_n = k_n ? 3'b010 : 3'b001;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         k        <= 1'b0;
         r        <= '0;
         c        <= '0;
         mx       <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         crd      <= 1'b0;
         cwr      <= 1'b0;
         csel     <= 3'b000;
         caddr_rd <= '0;
         caddr_wr <= '0;
         cdata_wr <= '0;
      end else begin
         state    <= state_n;
         k        <= k_n;
         r        <= r_n;
         c        <= c_n;
         mx       <= mx_n;
         busy     <= busy_n;
         done     <= done_n;
         crd      <= crd_n;
         cwr      <= cwr_n;
         csel     <= csel_n;
         caddr_rd <= caddr_rd_n;
         caddr_wr <= caddr_wr_n;
         cdata_wr <= cdata_wr_n;
      end
   end

endmodule

// File: tb/tb_cnn_maxpool_flatten.sv
// Bench for cnn_maxpool_flatten: layer-memory models, arithmetic pooling model,
// directed windows plus random images, busy-start, start-at-done and mid-run reset.
module tb_cnn_maxpool_flatten;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, crd, cwr;
   logic [11:0] caddr_rd, caddr_wr;
   logic [19:0] cdata_rd, cdata_wr;
   logic [2:0]  csel;

   cnn_maxpool_flatten dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .crd      (crd),
      .caddr_rd (caddr_rd),
      .cdata_rd (cdata_rd),
      .cwr      (cwr),
      .caddr_wr (caddr_wr),
      .cdata_wr (cdata_wr),
      .csel     (csel)
   );

   always #5 clk = ~clk;

   logic [19:0] l0a [4096];
   logic [19:0] l0b [4096];
   logic [19:0] l1a [1024];
   logic [19:0] l1b [1024];
   logic [19:0] l2  [2048];
   logic [19:0] exp_pool [2048];

   int rd_idx, wr_idx, seq_err, overlap;
   int total  = 0;
   int passed = 0;

`ifdef MAXPOOL_CEIL_EN
   localparam logic [19:0] E2  = 20'h00040;
   localparam logic [19:0] E3  = 20'h12350;
   localparam logic [19:0] E4B = 20'h7FFF0;
`else
   localparam logic [19:0] E2  = 20'h00035;
   localparam logic [19:0] E3  = 20'h12345;
   localparam logic [19:0] E4B = 20'h7FFF1;
`endif

   // Reference: read m is word (m%4) of the window of pixel m/4.
   function automatic logic [11:0] exp_rd_addr(input int m);
      int pix, j, p, r, c, off;
      pix = m / 4;
      j   = m % 4;
      p   = pix % 1024;
      r   = p / 32;
      c   = p % 32;
      off = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 64 : 65;
      return 12'((2*r)*64 + 2*c + off);
   endfunction

   function automatic logic [2:0] exp_rd_sel(input int m);
      return (m / 4 >= 1024) ? 3'b010 : 3'b001;
   endfunction

   function automatic logic [11:0] exp_wr_addr(input int n);
      int pix, k, p;
      pix = n / 2;
      k   = pix / 1024;
      p   = pix % 1024;
      return (n % 2 == 0) ? 12'(p) : 12'(2*p + k);
   endfunction

   function automatic logic [2:0] exp_wr_sel(input int n);
      if (n % 2 == 1) return 3'b101;
      return (n / 2 >= 1024) ? 3'b100 : 3'b011;
   endfunction

   function automatic logic [19:0] model(input int k, input int p);
      int r, c, a, m, v;
      logic [19:0] w;
      r = p / 32;
      c = p % 32;
      a = (2*r)*64 + 2*c;
      m = -(1 << 30);
      for (int j = 0; j < 4; j++) begin
         int ad;
         ad = a + ((j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 64 : 65);
         w  = (k != 0) ? l0b[ad] : l0a[ad];
         v  = int'($signed(w));
         if (v > m) m = v;
      end
`ifdef MAXPOOL_CEIL_EN
      if ((m & 15) != 0) begin
         if ((m >>> 4) == 32767) m = 'h7FFF0;
         else m = ((m >>> 4) + 1) * 16;
      end
`endif
      return 20'(m);
   endfunction

   // Layer memories: 1-cycle read latency, write captured at posedge.
   always @(posedge clk) begin
      if (reset) begin
         rd_idx  <= 0;
         wr_idx  <= 0;
         seq_err <= 0;
         overlap <= 0;
         for (int i = 0; i < 1024; i++) begin
            l1a[i] <= 20'hABCDE;
            l1b[i] <= 20'hABCDE;
         end
         for (int i = 0; i < 2048; i++) l2[i] <= 20'hABCDE;
      end else begin
         if (crd && cwr) overlap <= overlap + 1;
         if (crd) begin
            if (rd_idx >= 8192 || caddr_rd !== exp_rd_addr(rd_idx) ||
                csel !== exp_rd_sel(rd_idx))
               seq_err <= seq_err + 1;
            rd_idx <= rd_idx + 1;
            case (csel)
               3'b001:  cdata_rd <= l0a[caddr_rd];
               3'b010:  cdata_rd <= l0b[caddr_rd];
               3'b011:  cdata_rd <= l1a[caddr_rd[9:0]];
               3'b100:  cdata_rd <= l1b[caddr_rd[9:0]];
               3'b101:  cdata_rd <= l2[caddr_rd[10:0]];
               default: cdata_rd <= 'x;
            endcase
         end
         if (cwr) begin
            if (wr_idx >= 4096 || caddr_wr !== exp_wr_addr(wr_idx) ||
                csel !== exp_wr_sel(wr_idx) ||
                cdata_wr !== exp_pool[(wr_idx / 2) % 2048])
               seq_err <= seq_err + 1;
            wr_idx <= wr_idx + 1;
            case (csel)
               3'b011:  l1a[caddr_wr[9:0]] <= cdata_wr;
               3'b100:  l1b[caddr_wr[9:0]] <= cdata_wr;
               3'b101:  l2[caddr_wr[10:0]] <= cdata_wr;
               default: ;
            endcase
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_busy"},     32'(busy),     0);
      check({tag, "_done"},     32'(done),     0);
      check({tag, "_crd"},      32'(crd),      0);
      check({tag, "_cwr"},      32'(cwr),      0);
      check({tag, "_csel"},     32'(csel),     0);
      check({tag, "_caddr_rd"}, 32'(caddr_rd), 0);
      check({tag, "_caddr_wr"}, 32'(caddr_wr), 0);
      check({tag, "_cdata_wr"}, 32'(cdata_wr), 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic fill_l0(input bit zero);
      for (int i = 0; i < 4096; i++) begin
         l0a[i] = zero ? 20'h0 : 20'($urandom);
         l0b[i] = zero ? 20'h0 : 20'($urandom);
      end
   endtask

   task automatic do_run(input string tag, input int extra_at,
                         input bit start_at_done);
      int cnt;
      bit got;
      pulse_reset();
      for (int i = 0; i < 2048; i++) exp_pool[i] = model(i / 1024, i % 1024);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_busy_on"}, 32'(busy), 1);
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 20000) begin
         if (cnt == extra_at) start = 1'b1;
         @(posedge clk);
         #1;
         start = 1'b0;
         cnt++;
         if (done) got = 1'b1;
      end
      check({tag, "_done_seen"},    32'(got),     1);
      check({tag, "_done_latency"}, 32'(cnt),     14336);
      check({tag, "_busy_at_done"}, 32'(busy),    0);
      check({tag, "_write_count"},  32'(wr_idx),  4096);
      check({tag, "_read_count"},   32'(rd_idx),  8192);
      check({tag, "_sequence"},     32'(seq_err), 0);
      check({tag, "_crd_cwr_excl"}, 32'(overlap), 0);
      if (start_at_done) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, "_done_1cyc"},  32'(done), 0);
      check({tag, "_idle_busy"},  32'(busy), 0);
      @(posedge clk);
      #1;
      check({tag, "_idle_busy2"}, 32'(busy), 0);
      check({tag, "_idle_crd"},   32'(crd),  0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check_idle("rst");

      // All-zero image.
      fill_l0(1'b1);
      do_run("zero", -1, 1'b0);
      check("zero_l1a5",    32'(l1a[5]),    0);
      check("zero_l1b1023", 32'(l1b[1023]), 0);
      check("zero_l2_2047", 32'(l2[2047]),  0);

      // Random image with directed windows; extra start mid-run and at done.
      fill_l0(1'b0);
      l0a[0]    = 20'h00010;
      l0a[1]    = 20'h00035;
      l0a[64]   = 20'h00020;
      l0a[65]   = 20'h00034;
      l0b[4030] = 20'h0;
      l0b[4031] = 20'h0;
      l0b[4094] = 20'h0;
      l0b[4095] = 20'h12345;
      l0a[2]    = 20'hFFFF0;
      l0a[3]    = 20'h00000;
      l0a[66]   = 20'hFFFE0;
      l0a[67]   = 20'hFFFF8;
      l0a[4]    = 20'h7FFF1;
      l0a[5]    = 20'h00001;
      l0a[68]   = 20'h80000;
      l0a[69]   = 20'h7FFF0;
      do_run("dir", 100, 1'b1);
      check("dir_l1a0",    32'(l1a[0]),    32'(E2));
      check("dir_l2_0",    32'(l2[0]),     32'(E2));
      check("dir_l1b1023", 32'(l1b[1023]), 32'(E3));
      check("dir_l2_2047", 32'(l2[2047]),  32'(E3));
      check("dir_signed",  32'(l1a[1]),    0);
      check("dir_l2_2",    32'(l2[2]),     0);
      check("dir_sat",     32'(l1a[2]),    32'(E4B));
      check("dir_l2_4",    32'(l2[4]),     32'(E4B));

      // Mid-run asynchronous reset, then a clean run on fresh data.
      fill_l0(1'b0);
      pulse_reset();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5000) @(posedge clk);
      #1;
      check("abort_busy_before", 32'(busy), 1);
      reset = 1'b1;
      #1;
      check_idle("abort");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort_no_write", 32'(wr_idx), 0);
      check("abort_no_read",  32'(rd_idx), 0);
      check("abort_idle",     32'(busy),   0);
      fill_l0(1'b0);
      do_run("rerun", -1, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
